period_synth: RTL
=================

Name: period_synth

Overview:
Period-driven waveform generator. It is the inverse of the period detector: it takes a period in clock cycles and emits a 16-bit signed waveform, one sample per clock, whose neg-to-pos MSB transitions recur at exactly that period. It sits on the autotune resynthesis path and is fed by the corrected-pitch period. Period changes take effect only at cycle boundaries, which keeps the output phase-continuous.

Parameters:
DEFAULT_PERIOD, 139, active period after reset (clock cycles)
MIN_PERIOD, 16, lower clamp for requested period
MAX_PERIOD, 4096, upper clamp for requested period
AMPLITUDE, 16'h4000, square-wave magnitude (signed positive)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
period_in  in  16  requested period, unsigned cycles
period_valid  in  1  single-cycle strobe qualifying period_in
mode  in  1  0 = square, 1 = sawtooth
wave_out  out  16  signed output sample
cycle_start  out  1  high on the clock whose wave_out is sample 0 of a cycle
period_active  out  16  period currently being generated
busy  out  1  step divider running; requests ignored while high

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values:
  - wave_out=0, cycle_start=0, busy=0.
  - period_active=DEFAULT_PERIOD. Active step = floor(65536/DEFAULT_PERIOD), computed at elaboration (471 for the default).
  - Phase counter ph=0, pending_valid=0.
- Phase counter:
  - ph counts 0..P-1, one step per clock, where P = period_active.
  - After P-1 it wraps to 0.
  - The first clock after reset deasserts outputs sample ph=0.
- Output registration: wave_out and cycle_start are registered together. cycle_start=1 exactly when wave_out carries the ph=0 sample, giving one pulse every P clocks.
- Square mode (mode=0):
  - wave_out = +AMPLITUDE for ph < (P>>1).
  - wave_out = -AMPLITUDE otherwise.
- Sawtooth mode (mode=1):
  - Accumulator is loaded with 16'h8000 at ph=0 and adds step on each later sample.
  - wave_out = accumulator.
  - Maximum value is -32768 + (P-1)*step, which is at most 32767, so the accumulator never overflows.
- Mode change: takes effect on the next sample. Phase is not reset.
- Request acceptance:
  - A request is accepted only when period_valid=1 and busy=0. If busy=1, the request is silently dropped.
  - On accept: Pc = clamp(period_in, MIN_PERIOD, MAX_PERIOD), pending_valid is cleared, busy=1.
- Step divider:
  - Restoring serial divider computes 65536/Pc, 17 quotient bits, one per clock.
  - busy stays high for exactly 17 clocks.
  - On completion: pending_period=Pc, pending_step=quotient, pending_valid=1, busy=0.
- Period update at cycle boundary:
  - When ph==P-1 and pending_valid=1, the next clock loads the active period and step from the pending values.
  - pending_valid clears on that load.
  - The new cycle (ph=0, cycle_start=1) uses the new P.
- Boundary conditions:
  - Divider completes on the ph==P-1 clock: the update is applied at the following boundary, not the current one.
  - A new request arrives while a result is pending and busy=0: the new request is accepted and the old pending value is discarded.
  - Requested period equals the current period: processed normally, with no visible glitch.
- Reset mid-operation: divider aborted, pending discarded, all values as listed under reset values.

Optional Feature:
IMMEDIATE_UPDATE_EN
- Defined: on divider completion the pending period and step are loaded on the next clock regardless of ph. ph restarts at 0, cycle_start pulses, and the sawtooth accumulator reloads 16'h8000. pending_valid is therefore never observed high.
- Undefined: boundary-aligned update exactly as in Behaviour.

Test Plan:
1. Release reset, mode=0, no requests -> cycle_start every 139 clocks; each cycle has 69 samples of 16'h4000 followed by 70 samples of 16'hC000; period_active=139.
2. Release reset, mode=1 -> cycle_start sample = 16'h8000; each sample +471; last sample of cycle = 32230; next sample = 16'h8000.
3. period_in=200 strobed at ph=50 -> busy high for 17 clocks; the current cycle still lasts 139; the following cycles last 200 with step 327; period_active changes on that cycle_start.
4. period_in=5, then later period_in=10000 -> period_active becomes 16 (step 4096), then 4096 (step 16).
5. period_in=300, then period_in=400 two clocks later (busy=1) -> 400 dropped; period_active ends at 300.
6. Assert reset at ph=70 while busy=1 -> wave_out=0 and busy=0 with no clock edge; after release, the 139-cycle period resumes and the 300 request is lost.

Source files
------------

// File: rtl/period_synth.sv
// -----------------------------------------------------------------------------
// period_synth
//
// Period-driven waveform generator for the autotune resynthesis path. Takes a
// period in clock cycles and emits one signed 16-bit sample per clock (square
// or sawtooth) whose cycle repeats at exactly that period. New periods go
// through a 17-clock serial divider that derives the sawtooth step
// (65536 / period), and by default are applied only at a cycle boundary so
// the output stays phase-continuous.
//
// Optional feature macro: IMMEDIATE_UPDATE_EN
//   defined   : a finished divider result is applied on the next clock,
//               restarting the cycle at sample 0.
//   undefined : the result is held pending and applied at the next boundary.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   period_in     in   requested period (unsigned cycles), qualified by
//                      period_valid
//   period_valid  in   single-cycle request strobe
//   mode          in   0 = square, 1 = sawtooth
//   wave_out      out  signed output sample
//   cycle_start   out  high while wave_out carries sample 0 of a cycle
//   period_active out  period of the cycle wave_out belongs to
//   busy          out  divider running; requests are dropped while high
// -----------------------------------------------------------------------------
module period_synth #(
  parameter int unsigned DEFAULT_PERIOD = 139,
  parameter int unsigned MIN_PERIOD     = 16,
  parameter int unsigned MAX_PERIOD     = 4096,
  parameter logic [15:0] AMPLITUDE      = 16'h4000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] period_in,
  input  logic        period_valid,
  input  logic        mode,
  output logic [15:0] wave_out,
  output logic        cycle_start,
  output logic [15:0] period_active,
  output logic        busy
);

  localparam logic [15:0] DEFAULT_P     = 16'(DEFAULT_PERIOD);
  localparam logic [15:0] DEFAULT_STEP  = 16'(65536 / DEFAULT_PERIOD);
  localparam logic [15:0] MIN_P         = 16'(MIN_PERIOD);
  localparam logic [15:0] MAX_P         = 16'(MAX_PERIOD);
  localparam logic [15:0] NEG_AMPLITUDE = ~AMPLITUDE + 16'd1;
  localparam logic [15:0] SAW_START     = 16'h8000;
  localparam int          DIV_BITS      = 17;
  localparam logic [4:0]  DIV_LAST      = 5'(DIV_BITS - 1);

  // Active generator state
  logic [15:0] r_period;
  logic [15:0] r_step;
  logic [15:0] r_ph;
  logic [15:0] r_acc;

  // Registered outputs
  logic [15:0] r_wave;
  logic        r_cs;
  logic [15:0] r_period_out;

  // Serial divider
  logic        r_busy;
  logic [4:0]  r_div_cnt;
  logic [15:0] r_div_divisor;
  logic [15:0] r_div_rem;
  logic [15:0] r_div_quot;

`ifndef IMMEDIATE_UPDATE_EN
  // Finished divider result waiting for the next cycle boundary
  logic [15:0] r_pend_period;
  logic [15:0] r_pend_step;
  logic        r_pend_valid;
`endif

  logic        w_last;
  logic [15:0] w_saw;
  logic [15:0] w_square;
  logic [15:0] w_clamped;
  logic        w_div_in_bit;
  logic [15:0] w_rem_shift;
  logic        w_rem_ge;
  logic [15:0] w_rem_next;
  logic [15:0] w_quot_next;

  assign w_last = (r_ph == r_period - 16'd1);

  // Sample for the current phase; the accumulator restarts at every sample 0
  // so the step can change at a boundary without a discontinuity mid-cycle.
  assign w_saw    = (r_ph == '0) ? SAW_START : r_acc + r_step;
  assign w_square = (r_ph < (r_period >> 1)) ? AMPLITUDE : NEG_AMPLITUDE;

  assign w_clamped = (period_in < MIN_P) ? MIN_P :
                     (period_in > MAX_P) ? MAX_P : period_in;

  // Dividend is 65536: only its top bit (fed on the first step) is set.
  // Remainder stays below the divisor (<= 4096), so the shifted value fits
  // in 16 bits. The 17th quotient bit is always 0 for divisors >= 16, so a
  // 16-bit shift register holding the low quotient bits is sufficient.
  assign w_div_in_bit = (r_div_cnt == '0);
  assign w_rem_shift  = (r_div_rem << 1) | {15'd0, w_div_in_bit};
  assign w_rem_ge     = (w_rem_shift >= r_div_divisor);
  assign w_rem_next   = w_rem_ge ? (w_rem_shift - r_div_divisor) : w_rem_shift;
  assign w_quot_next  = (r_div_quot << 1) | {15'd0, w_rem_ge};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register below sees the pre-edge values of the others regardless of
  // statement order; later assignments in the block win on conflict.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_period      <= DEFAULT_P;
      r_step        <= DEFAULT_STEP;
      r_ph          <= '0;
      r_acc         <= '0;
      r_wave        <= '0;
      r_cs          <= 1'b0;
      r_period_out  <= DEFAULT_P;
      r_busy        <= 1'b0;
      r_div_cnt     <= '0;
      r_div_divisor <= '0;
      r_div_rem     <= '0;
      r_div_quot    <= '0;
`ifndef IMMEDIATE_UPDATE_EN
      r_pend_period <= '0;
      r_pend_step   <= '0;
      r_pend_valid  <= 1'b0;
`endif
    end else begin
      // Output sample for the current phase, tagged with its period
      r_wave       <= mode ? w_saw : w_square;
      r_cs         <= (r_ph == '0);
      r_period_out <= r_period;
      r_acc        <= w_saw;

      // Phase advance; a pending period takes over exactly at the wrap
      if (w_last) begin
        r_ph <= '0;
`ifndef IMMEDIATE_UPDATE_EN
        if (r_pend_valid) begin
          r_period     <= r_pend_period;
          r_step       <= r_pend_step;
          r_pend_valid <= 1'b0;
        end
`endif
      end else begin
        r_ph <= r_ph + 16'd1;
      end

      // Request intake and step divider
      if (r_busy) begin
        r_div_rem  <= w_rem_next;
        r_div_quot <= w_quot_next;
        r_div_cnt  <= r_div_cnt + 5'd1;
        if (r_div_cnt == DIV_LAST) begin
          r_busy <= 1'b0;
`ifdef IMMEDIATE_UPDATE_EN
          r_period <= r_div_divisor;
          r_step   <= w_quot_next;
          r_ph     <= '0;
`else
          // A result finishing on the wrap clock waits for the next wrap,
          // because the wrap above saw the old pending flag.
          r_pend_period <= r_div_divisor;
          r_pend_step   <= w_quot_next;
          r_pend_valid  <= 1'b1;
`endif
        end
      end else if (period_valid) begin
        r_busy        <= 1'b1;
        r_div_cnt     <= '0;
        r_div_divisor <= w_clamped;
        r_div_rem     <= '0;
        r_div_quot    <= '0;
`ifndef IMMEDIATE_UPDATE_EN
        // A newer request supersedes any result still waiting
        r_pend_valid  <= 1'b0;
`endif
      end
    end
  end

  assign wave_out      = r_wave;
  assign cycle_start   = r_cs;
  assign period_active = r_period_out;
  assign busy          = r_busy;

endmodule
